// File: rtl/pulse_cmd_queue_if.sv
// Host byte stream, queue drain and error signals between the host and pulse_cmd_queue.
// The master drives bytes, pops and error clears; the slave is the queue itself.
interface pulse_cmd_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  frame_abort;
    logic [31:0]           fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  bad_cmd_err;
    logic                  underrun_err;
    logic                  err_clr;

    modport master (
        output byte_in, byte_valid, frame_abort, fifo_rd_en, err_clr,
        input  byte_ready, fifo_dout, fifo_empty, fifo_count, bad_cmd_err, underrun_err
    );

    modport slave (
        input  byte_in, byte_valid, frame_abort, fifo_rd_en, err_clr,
        output byte_ready, fifo_dout, fifo_empty, fifo_count, bad_cmd_err, underrun_err
    );
endinterface

// File: rtl/pulse_cmd_queue.sv
// Assembles host bytes into 32-bit pulse commands (cmd byte first), validates the command
// and buffers good words in a first-word-fall-through queue drained by the pulse generator.
module pulse_cmd_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic              clk,
    input logic              rst,
    pulse_cmd_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    localparam logic [2:0] ST_B3   = 3'd0;
    localparam logic [2:0] ST_B2   = 3'd1;
    localparam logic [2:0] ST_B1   = 3'd2;
    localparam logic [2:0] ST_B0   = 3'd3;
    localparam logic [2:0] ST_PUSH = 3'd4;

    localparam logic [7:0] CMD_PULSE     = 8'h01;
    localparam logic [7:0] CMD_SET_DELAY = 8'h02;
    localparam logic [7:0] CMD_FLUSH     = 8'hFF;

    logic [2:0]            state;
    logic [31:0]           word;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  empty_q;
    logic                  bad_q;
    logic                  underrun_q;

    logic accept, in_push, is_enq, is_flush, full, pop, push, flush, stall, drop_bad, underrun_set;

    assign bus.byte_ready = (state != ST_PUSH);
    assign accept   = bus.byte_valid && bus.byte_ready && !bus.frame_abort;
    assign in_push  = (state == ST_PUSH) && !bus.frame_abort;
    assign is_enq   = (word[31:24] == CMD_PULSE) || (word[31:24] == CMD_SET_DELAY);
    assign is_flush = (word[31:24] == CMD_FLUSH);
    assign full     = (count == FULL_COUNT);
    assign pop      = bus.fifo_rd_en && !empty_q;
    assign flush    = in_push && is_flush;
    // A full queue still accepts the word when the generator pops in the same cycle.
    assign push     = in_push && is_enq && (!full || pop);
    assign stall    = in_push && is_enq && full && !pop;
    assign drop_bad = in_push && !is_enq && !is_flush;
    assign underrun_set = bus.fifo_rd_en && empty_q && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_B3;
            word  <= '0;
        end else if (bus.frame_abort) begin
            state <= ST_B3;
        end else begin
            case (state)
                ST_B3:   if (accept) begin word[31:24] <= bus.byte_in; state <= ST_B2;   end
                ST_B2:   if (accept) begin word[23:16] <= bus.byte_in; state <= ST_B1;   end
                ST_B1:   if (accept) begin word[15:8]  <= bus.byte_in; state <= ST_B0;   end
                ST_B0:   if (accept) begin word[7:0]   <= bus.byte_in; state <= ST_PUSH; end
                ST_PUSH: if (!stall) state <= ST_B3;
                default: state <= ST_B3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            empty_q <= (count_next == '0);
        end
    end

    // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (drop_bad)         bad_q <= 1'b1;
            else if (bus.err_clr) bad_q <= 1'b0;
            if (underrun_set)     underrun_q <= 1'b1;
            else if (bus.err_clr) underrun_q <= 1'b0;
        end
    end

    assign bus.fifo_dout    = empty_q ? 32'h0 : mem[rd_ptr];
    assign bus.fifo_empty   = empty_q;
    assign bus.fifo_count   = count;
    assign bus.bad_cmd_err  = bad_q;
    assign bus.underrun_err = underrun_q;
endmodule

// File: tb/tb_pulse_cmd_queue.sv
// Directed self-checking bench for pulse_cmd_queue: assembly latency, full stall,
// frame abort, flush, bad command, sticky errors and pointer wrap.
module tb_pulse_cmd_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pulse_cmd_queue_if #(.DEPTH_LOG2(4)) bus();

    pulse_cmd_queue #(.DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.frame_abort = 1'b0;
        bus.fifo_rd_en = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits (bounded) for byte_ready, then presents one byte across the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        int wait_cyc = 0;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        while (!bus.byte_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.byte_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL byte_ready_timeout: byte_ready=%b after %0d cycles, required 1", bus.byte_ready, wait_cyc);
        end
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        send_word(32'h01000001);
        release_bus();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: count=%0d empty=%b, required 0/1", bus.fifo_count, bus.fifo_empty);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.byte_ready !== 1'b1 || bus.fifo_dout !== 32'h0 || bus.bad_cmd_err !== 1'b0 || bus.underrun_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: ready=%b dout=%h bad=%b under=%b, required 1/00000000/0/0",
                     bus.byte_ready, bus.fifo_dout, bus.bad_cmd_err, bus.underrun_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_word(32'h01123456);
        release_bus();
        tests_run++;
        if (bus.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: empty=%b one cycle after last byte, required 1", bus.fifo_empty);
        end
        @(negedge clk);
        tests_run++;
        if (bus.fifo_dout !== 32'h01123456 || bus.fifo_empty !== 1'b0 || bus.fifo_count !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL basic_word: dout=%h empty=%b count=%0d, required 01123456/0/1",
                     bus.fifo_dout, bus.fifo_empty, bus.fifo_count);
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int i = 0; i < 16; i++) send_word({8'h01, 16'h0000, 8'(i)});
        release_bus();
        @(negedge clk);
        tests_run++;
        if (bus.fifo_count !== 5'd16 || bus.byte_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_count: count=%0d ready=%b, required 16/1", bus.fifo_count, bus.byte_ready);
        end
        send_word(32'h01ABCDEF);
        release_bus();
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.byte_ready !== 1'b0 || bus.fifo_count !== 5'd16) begin
            tests_failed++;
            $display("[TB] FAIL full_stall: ready=%b count=%0d, required 0/16", bus.byte_ready, bus.fifo_count);
        end
        bus.fifo_rd_en = 1'b1;
        @(negedge clk);
        bus.fifo_rd_en = 1'b0;
        tests_run++;
        if (bus.fifo_count !== 5'd16 || bus.byte_ready !== 1'b1 || bus.fifo_dout !== 32'h01000001) begin
            tests_failed++;
            $display("[TB] FAIL push_pop_full: count=%0d ready=%b dout=%h, required 16/1/01000001",
                     bus.fifo_count, bus.byte_ready, bus.fifo_dout);
        end
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] exp_w;
            exp_w = (i == 16) ? 32'h01ABCDEF : {8'h01, 16'h0000, 8'(i)};
            @(negedge clk);
            tests_run++;
            if (bus.fifo_dout !== exp_w || bus.fifo_empty !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL drain_%0d: dout=%h empty=%b, required %h/0", i, bus.fifo_dout, bus.fifo_empty, exp_w);
            end
            bus.fifo_rd_en = 1'b1;
            @(negedge clk);
            bus.fifo_rd_en = 1'b0;
        end
        tests_run++;
        if (bus.fifo_empty !== 1'b1 || bus.fifo_count !== 5'd0 || bus.underrun_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drain_end: empty=%b count=%0d under=%b, required 1/0/0",
                     bus.fifo_empty, bus.fifo_count, bus.underrun_err);
        end
    endtask

    task automatic test_abort();
        do_reset();
        send_byte(8'h01);
        send_byte(8'hAA);
        @(negedge clk);
        bus.byte_in = 8'h55;
        bus.byte_valid = 1'b1;
        bus.frame_abort = 1'b1;
        @(negedge clk);
        bus.frame_abort = 1'b0;
        bus.byte_valid = 1'b0;
        send_word(32'h02001005);
        release_bus();
        @(negedge clk);
        tests_run++;
        if (bus.fifo_count !== 5'd1 || bus.fifo_dout !== 32'h02001005 || bus.bad_cmd_err !== 1'b0 || bus.underrun_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_word: count=%0d dout=%h bad=%b under=%b, required 1/02001005/0/0",
                     bus.fifo_count, bus.fifo_dout, bus.bad_cmd_err, bus.underrun_err);
        end
    endtask

    task automatic test_flush();
        do_reset();
        send_word(32'h01000011);
        send_word(32'h02000022);
        send_word(32'h01000033);
        send_word(32'hFF000000);
        release_bus();
        tests_run++;
        if (bus.fifo_count !== 5'd3) begin
            tests_failed++;
            $display("[TB] FAIL pre_flush_count: count=%0d, required 3", bus.fifo_count);
        end
        @(negedge clk);
        tests_run++;
        if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1 || bus.bad_cmd_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush: count=%0d empty=%b bad=%b, required 0/1/0",
                     bus.fifo_count, bus.fifo_empty, bus.bad_cmd_err);
        end
        send_word(32'hFF000000);
        release_bus();
        bus.fifo_rd_en = 1'b1;
        @(negedge clk);
        bus.fifo_rd_en = 1'b0;
        tests_run++;
        if (bus.underrun_err !== 1'b0 || bus.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_vs_read: under=%b empty=%b, required 0/1", bus.underrun_err, bus.fifo_empty);
        end
    endtask

    task automatic test_bad_cmd();
        do_reset();
        send_word(32'h7E000000);
        release_bus();
        @(negedge clk);
        tests_run++;
        if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1 || bus.bad_cmd_err !== 1'b1 || bus.underrun_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bad_cmd: count=%0d empty=%b bad=%b under=%b, required 0/1/1/0",
                     bus.fifo_count, bus.fifo_empty, bus.bad_cmd_err, bus.underrun_err);
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        tests_run++;
        if (bus.bad_cmd_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clr_bad: bad=%b, required 0", bus.bad_cmd_err);
        end
        bus.fifo_rd_en = 1'b1;
        @(negedge clk);
        bus.fifo_rd_en = 1'b0;
        tests_run++;
        if (bus.underrun_err !== 1'b1 || bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL underrun: under=%b count=%0d empty=%b, required 1/0/1",
                     bus.underrun_err, bus.fifo_count, bus.fifo_empty);
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.underrun_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clr_under: under=%b, required 0", bus.underrun_err);
        end
        bus.fifo_rd_en = 1'b1;
        @(negedge clk);
        bus.fifo_rd_en = 1'b0;
        bus.err_clr = 1'b0;
        tests_run++;
        if (bus.underrun_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL set_beats_clear: under=%b, required 1", bus.underrun_err);
        end
    endtask

    function automatic logic [31:0] wrap_word(input int i);
        return {8'h02, 8'h60, 8'(i * 7), 8'(i)};
    endfunction

    task automatic test_wrap();
        int got = 0;
        int max_count = 0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 20; i++) send_word(wrap_word(i));
                release_bus();
            end
            begin
                int cyc = 0;
                while (got < 20 && cyc < 2000) begin
                    @(negedge clk);
                    bus.fifo_rd_en = 1'b0;
                    cyc++;
                    if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
                    if ((cyc % 2 == 0) && !bus.fifo_empty) begin
                        tests_run++;
                        if (bus.fifo_dout !== wrap_word(got)) begin
                            tests_failed++;
                            $display("[TB] FAIL wrap_order_%0d: dout=%h, required %h", got, bus.fifo_dout, wrap_word(got));
                        end
                        got++;
                        bus.fifo_rd_en = 1'b1;
                    end
                end
                @(negedge clk);
                bus.fifo_rd_en = 1'b0;
            end
        join
        tests_run++;
        if (got != 20 || max_count > 16) begin
            tests_failed++;
            $display("[TB] FAIL wrap_summary: words=%0d max_count=%0d, required 20/<=16", got, max_count);
        end
        @(negedge clk);
        tests_run++;
        if (bus.fifo_empty !== 1'b1 || bus.underrun_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_end: empty=%b under=%b, required 1/0", bus.fifo_empty, bus.underrun_err);
        end
    endtask

    initial begin
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.frame_abort = 1'b0;
        bus.fifo_rd_en = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_basic();
        test_full_stall();
        test_abort();
        test_flush();
        test_bad_cmd();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
